fsm: RTL and testbench



---
 rtl/fsm.sv | 117 +++++++++++
 tb/tb_fsm.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fsm.sv
// -----------------------------------------------------------------------------
// fsm - memory-access control state machine.
//
// Sequences one read or write access to the on-chip memory array each time the
// block is selected. The access phase lasts ACCESS_CYCLES clocks, after which
// a one-cycle completion pulse is raised. Holding sel high chains transactions
// back to back with a period of ACCESS_CYCLES+1 clocks.
//
// Parameters:
//   ACCESS_CYCLES  length of the access phase in clocks (1..16)
//
// Ports:
//   clk    in   system clock, rising-edge active
//   rst    in   synchronous active-high reset, overrides every other input
//   sel    in   memory select; 1 requests or holds a transaction
//   op     in   1 = write, 0 = read; sampled only on the start edge
//   rw     out  read/write strobe to the array (1 = write access)
//   valid  out  one-cycle pulse when a transaction completes
// -----------------------------------------------------------------------------
module fsm #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sel,
  input  logic op,
  output logic rw,
  output logic valid
);

  localparam int CW = $clog2(ACCESS_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic            op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rw_q, rw_d;
  logic            valid_q, valid_d;

  // Outputs are registered and computed from the next state, so they follow
  // the state register exactly and never see sel/op combinationally.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    rw_d    = 1'b0;
    valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sel) begin
          op_d    = op;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
          rw_d    = op;
        end
      end

      ACCESS: begin
        if (!sel) begin
          // Abort: drop straight back to idle, no completion pulse.
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = DONE;
          rw_d    = op_q;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          rw_d  = op_q;
        end
      end

      DONE: begin
        if (sel) begin
          // Back-to-back transaction; a fresh op is latched here.
          op_d    = op;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
          rw_d    = op;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        // Unused encoding: recover to idle with outputs low.
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      valid_q <= valid_d;
    end
  end

  assign rw    = rw_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_fsm.sv
module tb_fsm;

  localparam int AC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic op  = 1'b0;
  logic rw;
  logic valid;

  int errors = 0;
  int checks = 0;

  // Reference model: a transaction is described by how many edges have passed
  // since its start edge (phase), or -1 when none is in flight. The strobe
  // shows the latched op for phases 0..AC and completion is phase AC.
  int m_phase = -1;
  bit m_op    = 1'b0;

  fsm #(.ACCESS_CYCLES(AC)) dut (
    .clk   (clk),
    .rst   (rst),
    .sel   (sel),
    .op    (op),
    .rw    (rw),
    .valid (valid)
  );

  always #5 clk = ~clk;

  function automatic bit m_rw();
    return (m_phase >= 0) ? m_op : 1'b0;
  endfunction

  function automatic bit m_valid();
    return (m_phase == AC);
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit o);
    if (r) begin
      m_phase = -1;
      m_op    = 1'b0;
    end else if (m_phase < 0 || m_phase == AC) begin
      if (s) begin
        m_phase = 0;
        m_op    = o;
      end else begin
        m_phase = -1;
      end
    end else if (!s) begin
      m_phase = -1;
    end else begin
      m_phase = m_phase + 1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then sample 1 ns later.
  task automatic step(input bit r, input bit s, input bit o);
    rst = r;
    sel = s;
    op  = o;
    @(posedge clk);
    model_edge(r, s, o);
    #1;
  endtask

  // Directed step with hand-derived expected outputs, also cross-checked
  // against the model.
  task automatic dstep(input string tag, input bit r, input bit s, input bit o,
                       input bit erw, input bit ev);
    step(r, s, o);
    chk({tag, ".rw"},    rw,    erw);
    chk({tag, ".valid"}, valid, ev);
    chk({tag, ".model"}, {m_rw(), m_valid()} == {erw, ev}, 1'b1);
  endtask

  initial begin
    int vcount;
    // 1. Reset with sel/op high: nothing starts.
    dstep("rst0", 1, 1, 1, 0, 0);
    dstep("rst1", 1, 1, 1, 0, 0);

    // 2. Write transaction; op changes after E0 are ignored.
    dstep("wr_e0", 0, 1, 1, 1, 0);
    dstep("wr_e1", 0, 1, 0, 1, 0);
    dstep("wr_e2", 0, 1, 0, 1, 1);
    dstep("wr_e3", 0, 0, 0, 0, 0);

    // 3. Read with op toggling after the start edge.
    dstep("rd_e0", 0, 1, 0, 0, 0);
    dstep("rd_e1", 0, 1, 1, 0, 0);
    dstep("rd_e2", 0, 1, 1, 0, 1);
    dstep("rd_e3", 0, 0, 0, 0, 0);

    // 4. Back-to-back: sel high for 9 edges, ops 1/0/1 at start edges.
    dstep("b2b_e0", 0, 1, 1, 1, 0);
    dstep("b2b_e1", 0, 1, 0, 1, 0);
    dstep("b2b_e2", 0, 1, 0, 1, 1);
    dstep("b2b_e3", 0, 1, 0, 0, 0);
    dstep("b2b_e4", 0, 1, 1, 0, 0);
    dstep("b2b_e5", 0, 1, 1, 0, 1);
    dstep("b2b_e6", 0, 1, 1, 1, 0);
    dstep("b2b_e7", 0, 1, 0, 1, 0);
    dstep("b2b_e8", 0, 1, 0, 1, 1);
    dstep("b2b_e9", 0, 0, 0, 0, 0);

    // 5. Abort in ACCESS, then no pulse for 5 cycles.
    dstep("ab_e0", 0, 1, 1, 1, 0);
    dstep("ab_e1", 0, 0, 1, 0, 0);
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, i[0]);
      if (valid !== 1'b0) vcount++;
      chk("ab_idle_rw", rw, 1'b0);
    end
    chk("ab_no_valid", vcount == 0, 1'b1);

    // 6. Mid-transaction reset, then a fresh transaction with normal latency.
    dstep("mr_e0", 0, 1, 1, 1, 0);
    dstep("mr_e1", 1, 1, 1, 0, 0);
    dstep("mr_rel", 0, 0, 0, 0, 0);
    dstep("mr_n0", 0, 1, 1, 1, 0);
    dstep("mr_n1", 0, 1, 0, 1, 0);
    dstep("mr_n2", 0, 1, 0, 1, 1);
    dstep("mr_n3", 0, 0, 0, 0, 0);

    // Reset while in DONE with sel held: no pulse carried on, no restart.
    dstep("rd_d0", 0, 1, 1, 1, 0);
    dstep("rd_d1", 0, 1, 1, 1, 0);
    dstep("rd_d2", 0, 1, 1, 1, 1);
    dstep("rd_d3", 1, 1, 1, 0, 0);
    dstep("rd_d4", 0, 0, 1, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit r, s, o;
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) != 0);
      o = $urandom_range(0, 1);
      step(r, s, o);
      chk("rnd.rw",    rw,    m_rw());
      chk("rnd.valid", valid, m_valid());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
